// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: pulls words from a registered-count FIFO in bursts
// and hands them downstream through a 4-entry holding buffer with valid/ready.
//
// state | meaning
// IDLE  | waiting for count >= BURST_LEN, or a nonzero count while flush is high
// BURST | issuing rd_en while words are available and the buffer has room
// DRAIN | no new reads; waiting for in-flight reads to land in the buffer
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 7,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk_r,
  input  logic                  rst_n,
  input  logic [CNT_WIDTH-1:0]  fifo_count,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           rd_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] BURST_THR  = CNT_WIDTH'(BURST_LEN);
  localparam logic [3:0]           BURST_LAST = 4'(BURST_LEN - 1);

  state_t                  state, state_next;
  logic                    rd_q;
  logic [3:0]              burst_cnt;
  logic [DATA_WIDTH-1:0]   buf_mem [4];
  logic [1:0]              wr_ptr, rd_ptr;
  logic [2:0]              occ;
  logic [1:0]              pending;
  logic [3:0]              fill;
  logic                    has_avail, room, issue, start, push, pop;

  // The count lags a read being sampled this cycle, so discount it.
  assign has_avail = fifo_count > CNT_WIDTH'(rd_en);
  assign pending   = {1'b0, rd_en} + {1'b0, rd_q};
  assign fill      = {1'b0, occ} + {2'b00, pending};
  assign room      = fill < 4'd4;
  assign push      = rd_q;
  assign pop       = m_valid && m_ready;
  assign m_valid   = occ != 3'd0;
  assign m_data    = buf_mem[rd_ptr];
  assign busy      = state != IDLE;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count >= BURST_THR || (flush && fifo_count != '0)) begin
          state_next = BURST;
          start      = 1'b1;
        end
      end
      BURST: begin
        if (has_avail && room) begin
          issue = 1'b1;
          if (burst_cnt == BURST_LAST) state_next = DRAIN;
        end else if (!has_avail) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pending == 2'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      rd_q      <= 1'b0;
      burst_cnt <= 4'd0;
    end else begin
      state <= state_next;
      rd_en <= issue;
      rd_q  <= rd_en;
      if (start)      burst_cnt <= 4'd0;
      else if (issue) burst_cnt <= burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) buf_mem[i] <= '0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      occ      <= 3'd0;
      rd_count <= 16'd0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= fifo_data;
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        rd_count <= rd_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
